// File: rtl/bf16_operand_sequencer.sv
// Issue stage for bf16_unit: takes one command, packs its operands into the
// unit's slots, waits a fixed latency and returns the unit result over a
// valid/ready response channel, one operation at a time.
//
// state | meaning
// IDLE  | waiting for a command
// LOAD  | accepting operand words into slots
// WAIT  | operands held, counting down LATENCY to result sample
// RESP  | result or error held until consumed
module bf16_operand_sequencer #(
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_funct5,
    input  logic [4:0]  cmd_nops,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [15:0] op_data,
    output logic [15:0] unit_in1,
    output logic [15:0] unit_in2,
    output logic [15:0] unit_in3,
    output logic [15:0] unit_in4,
    output logic [15:0] unit_in5,
    output logic [15:0] unit_in6,
    output logic [15:0] unit_in7,
    output logic [15:0] unit_in8,
    output logic [15:0] unit_in9,
    output logic [15:0] unit_in10,
    output logic [15:0] unit_in11,
    output logic [15:0] unit_in12,
    output logic [15:0] unit_in13,
    output logic [15:0] unit_in14,
    output logic [15:0] unit_in15,
    output logic [15:0] unit_in16,
    output logic [15:0] unit_in17,
    output logic [15:0] unit_in18,
    output logic [4:0]  unit_funct5,
    input  logic [15:0] unit_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic        busy
);

    localparam int NSLOTS = 18;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

    state_t                   state, state_nxt;
    logic [NSLOTS-1:0][15:0]  slot_q;
    logic [4:0]               funct5_q;
    logic [4:0]               count_q;
    logic [4:0]               nops_q;
    logic [3:0]               wait_cnt_q;
    logic [15:0]              result_q;
    logic                     err_q;

    logic cmd_legal;
    logic last_op;
    logic wait_done;

    assign cmd_legal = (cmd_nops != 5'd0) && (cmd_nops <= 5'd18);
    assign last_op   = (count_q == nops_q - 5'd1);
    // Counter at 1 means this edge takes it to zero: the sample edge.
    assign wait_done = (wait_cnt_q == 4'd1);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode from handshakes and the wait counter.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cmd_valid) state_nxt = cmd_legal ? LOAD : RESP;
            LOAD: if (op_valid && last_op) state_nxt = WAIT;
            WAIT: if (wait_done) state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand slots, funct5, counters and response capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q     <= '0;
            funct5_q   <= '0;
            count_q    <= '0;
            nops_q     <= '0;
            wait_cnt_q <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        funct5_q <= cmd_funct5;
                        slot_q   <= '0;
                        count_q  <= '0;
                        nops_q   <= cmd_nops;
                        if (!cmd_legal) begin
                            err_q    <= 1'b1;
                            result_q <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (op_valid) begin
                        slot_q[count_q] <= op_data;
                        count_q         <= count_q + 5'd1;
                        if (last_op) wait_cnt_q <= 4'(LATENCY);
                    end
                end
                WAIT: begin
                    wait_cnt_q <= wait_cnt_q - 4'd1;
                    if (wait_done) begin
                        result_q <= unit_result;
                        err_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready  = (state == IDLE);
    assign op_ready   = (state == LOAD);
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);
    assign rsp_result = result_q;
    assign rsp_err    = err_q;

    assign unit_funct5 = funct5_q;
    assign unit_in1    = slot_q[0];
    assign unit_in2    = slot_q[1];
    assign unit_in3    = slot_q[2];
    assign unit_in4    = slot_q[3];
    assign unit_in5    = slot_q[4];
    assign unit_in6    = slot_q[5];
    assign unit_in7    = slot_q[6];
    assign unit_in8    = slot_q[7];
    assign unit_in9    = slot_q[8];
    assign unit_in10   = slot_q[9];
    assign unit_in11   = slot_q[10];
    assign unit_in12   = slot_q[11];
    assign unit_in13   = slot_q[12];
    assign unit_in14   = slot_q[13];
    assign unit_in15   = slot_q[14];
    assign unit_in16   = slot_q[15];
    assign unit_in17   = slot_q[16];
    assign unit_in18   = slot_q[17];

endmodule

// File: tb/tb_bf16_operand_sequencer.sv
// Bench for bf16_operand_sequencer: directed cases plus randomized commands,
// with a queue of expected responses checked by an independent monitor.
module tb_bf16_operand_sequencer;

    localparam int LAT = 3;

    typedef struct packed {
        logic [15:0]       res;
        logic              err;
        logic [4:0]        f5;
        logic [17:0][15:0] sl;
    } exp_t;

    logic        clk, reset;
    logic        cmd_valid, cmd_ready;
    logic [4:0]  cmd_funct5, cmd_nops;
    logic        op_valid, op_ready;
    logic [15:0] op_data;
    logic [17:0][15:0] uin;
    logic [4:0]  unit_funct5;
    logic [15:0] unit_result;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [15:0] rsp_result;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        stub_cyc = 1'b0;
    logic [15:0] stub_val = 16'h0;
    logic [15:0] op_buf [18];
    logic [15:0] last_exp_res = 16'h0;
    exp_t        exp_q [$];

    bf16_operand_sequencer #(.LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_funct5(cmd_funct5), .cmd_nops(cmd_nops),
        .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
        .unit_in1(uin[0]),   .unit_in2(uin[1]),   .unit_in3(uin[2]),
        .unit_in4(uin[3]),   .unit_in5(uin[4]),   .unit_in6(uin[5]),
        .unit_in7(uin[6]),   .unit_in8(uin[7]),   .unit_in9(uin[8]),
        .unit_in10(uin[9]),  .unit_in11(uin[10]), .unit_in12(uin[11]),
        .unit_in13(uin[12]), .unit_in14(uin[13]), .unit_in15(uin[14]),
        .unit_in16(uin[15]), .unit_in17(uin[16]), .unit_in18(uin[17]),
        .unit_funct5(unit_funct5), .unit_result(unit_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Free-running edge counter; the stub can present it as the unit result.
    always @(posedge clk) cyc <= cyc + 1;

    assign unit_result = stub_cyc ? cyc[15:0] : stub_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Monitor: one comparison set per response, on its first visible cycle.
    initial begin
        logic seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset || !rsp_valid) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    timeout("unexpected_response");
                end else begin
                    e = exp_q.pop_front();
                    last_exp_res = e.res;
                    chk("rsp_result", 32'(rsp_result), 32'(e.res));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("unit_funct5", 32'(unit_funct5), 32'(e.f5));
                    for (int i = 0; i < 18; i++)
                        chk($sformatf("slot%0d", i), 32'(uin[i]), 32'(e.sl[i]));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic do_cmd(input logic [4:0] f, input int n);
        int t = 0;
        cmd_valid  = 1'b1;
        cmd_funct5 = f;
        cmd_nops   = 5'(n);
        while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
        if (!cmd_ready) timeout("cmd_handshake");
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_legal(input logic [4:0] f, input int n, input int gapm);
        exp_t e;
        int t;
        e.err = 1'b0;
        e.f5  = f;
        e.sl  = '0;
        e.res = 16'h0;
        for (int i = 0; i < n; i++) e.sl[i] = op_buf[i];
        do_cmd(f, n);
        chk("op_ready_in_load", 32'(op_ready), 32'd1);
        chk("busy_in_load", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            int g;
            g = (gapm == 1) ? 1 : (gapm == 2) ? $urandom_range(0, 2) : 0;
            if (i > 0 && g > 0) begin
                op_valid = 1'b0;
                op_data  = 16'hDEAD;
                repeat (g) @(negedge clk);
            end
            op_valid = 1'b1;
            op_data  = op_buf[i];
            t = 0;
            while (!op_ready && t < 50) begin @(negedge clk); t++; end
            if (!op_ready) timeout("op_handshake");
            if (i == n - 1) begin
                if (n == 18) chk("slot17_before_last", 32'(uin[17]), 32'd0);
                e.res = stub_cyc ? 16'(cyc + LAT) : stub_val;
                exp_q.push_back(e);
            end
            @(negedge clk);
            op_valid = 1'b0;
        end
        chk("op_ready_after_last", 32'(op_ready), 32'd0);
        chk("rsp_not_early", 32'(rsp_valid), 32'd0);
    endtask

    task automatic run_illegal(input logic [4:0] f, input int n);
        exp_t e;
        e.res = 16'h0;
        e.err = 1'b1;
        e.f5  = f;
        e.sl  = '0;
        exp_q.push_back(e);
        do_cmd(f, n);
        chk("illegal_op_ready", 32'(op_ready), 32'd0);
        chk("illegal_rsp_now", 32'(rsp_valid), 32'd1);
    endtask

    task automatic do_rsp(input int hold);
        int t = 0;
        rsp_ready = 1'b0;
        while (!rsp_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rsp_valid) timeout("rsp_wait");
        repeat (hold) begin
            @(negedge clk);
            chk("rsp_valid_held", 32'(rsp_valid), 32'd1);
            chk("rsp_result_held", 32'(rsp_result), 32'(last_exp_res));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done", 32'(rsp_valid), 32'd0);
        chk("idle_after_rsp", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        cmd_valid = 1'b0; cmd_funct5 = '0; cmd_nops = '0;
        op_valid = 1'b0; op_data = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 18; i++) op_buf[i] = '0;
        #15 reset = 1'b1;
        #1;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_op_ready", 32'(op_ready), 32'd0);
        chk("reset_funct5", 32'(unit_funct5), 32'd0);
        for (int i = 0; i < 18; i++) chk($sformatf("reset_slot%0d", i), 32'(uin[i]), 32'd0);
        @(negedge clk);

        // Two operands, fixed stub result.
        stub_cyc = 1'b0; stub_val = 16'h4460;
        op_buf[0] = 16'h4458; op_buf[1] = 16'h3F80;
        run_legal(5'b00001, 2, 0);
        do_rsp(0);

        // Latency: result is the edge count LAT edges after the last write.
        stub_cyc = 1'b1;
        op_buf[0] = 16'h1234; op_buf[1] = 16'hABCD; op_buf[2] = 16'h0F0F;
        run_legal(5'b00010, 3, 0);
        do_rsp(0);

        // Full 18 operands with op_valid toggling.
        op_buf[0] = 16'h3DF8; op_buf[1] = 16'h3D55;
        for (int i = 2; i < 18; i++) op_buf[i] = 16'(16'h3C00 + i * 16'h0011);
        run_legal(5'b00111, 18, 1);
        do_rsp(0);

        // Illegal operand counts.
        run_illegal(5'b00011, 0);
        do_rsp(0);
        run_illegal(5'b00100, 19);
        do_rsp(0);

        // Response held under back-pressure.
        stub_cyc = 1'b0; stub_val = 16'hBEEF;
        op_buf[0] = 16'h4000;
        run_legal(5'b01000, 1, 0);
        do_rsp(5);

        // Reset in the middle of LOAD.
        for (int i = 0; i < 10; i++) op_buf[i] = 16'($urandom_range(1, 16'hFFFF));
        do_cmd(5'b01010, 10);
        for (int i = 0; i < 4; i++) begin
            op_valid = 1'b1; op_data = op_buf[i];
            @(negedge clk);
        end
        op_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_op_ready", 32'(op_ready), 32'd0);
        chk("midrst_funct5", 32'(unit_funct5), 32'd0);
        for (int i = 0; i < 4; i++) chk($sformatf("midrst_slot%0d", i), 32'(uin[i]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Randomized commands.
        for (int k = 0; k < 30; k++) begin
            logic [4:0] f;
            int n;
            f = 5'($urandom);
            stub_cyc = 1'($urandom_range(0, 1));
            stub_val = 16'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                n = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(19, 31);
                run_illegal(f, n);
            end else begin
                n = $urandom_range(1, 18);
                for (int i = 0; i < 18; i++) op_buf[i] = 16'($urandom);
                run_legal(f, n, 2);
            end
            do_rsp($urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bf16_operand_sequencer.md
Name: bf16_operand_sequencer

Overview:
Upstream issue stage for bf16_unit. Accepts a command (funct5 plus operand count), then a stream of 16-bit bf16 operands. It packs the operands into the unit's 18 operand slots, zero-filling unused slots, and holds them and funct5 stable for a fixed latency. It then captures the unit's result and returns it on a valid/ready response channel, replacing free-running operand drive with a handshaked, one-operation-at-a-time interface.

Parameters:
LATENCY, 3, cycles from entering WAIT to the clock edge at which unit_result is sampled; legal range 1..15
NSLOTS, 18, number of operand slots driven (unit_in1..unit_in18); fixed, not for override

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when high with cmd_valid
cmd_funct5  input  5  operation code forwarded to bf16_unit
cmd_nops  input  5  number of operands to follow; legal 1..18
op_valid  input  1  operand word offered
op_ready  output  1  operand accepted when high with op_valid
op_data  input  16  bf16 operand word
unit_in1..unit_in18  output  16 each  registered operand slots to bf16_unit in1..in18
unit_funct5  output  5  registered funct5 to bf16_unit
unit_result  input  16  result from bf16_unit
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when high with rsp_valid
rsp_result  output  16  captured result
rsp_err  output  1  high with rsp_valid when the command was illegal
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; all slots, unit_funct5, rsp_result, rsp_err, the count and the wait counter = 0. Outputs at reset: cmd_ready=1, all other outputs=0.
- Reset mid-operation aborts the operation. No response is produced and the in-flight command is lost.
- States: IDLE, LOAD, WAIT, RESP. cmd_ready, op_ready, rsp_valid and busy are decoded from state only.
- IDLE: cmd_ready=1.
  - On a cmd handshake: latch cmd_funct5 into unit_funct5, clear all 18 slots to 0, clear count to 0.
  - If cmd_nops in 1..18, go to LOAD.
  - Otherwise (0 or >18): set rsp_err=1 and rsp_result=0, and go to RESP.
- LOAD: op_ready=1.
  - Each op handshake writes op_data into slot[count] (slot 0 = unit_in1) and increments count.
  - The handshake that writes slot nops-1 loads the wait counter with LATENCY and moves to WAIT.
  - No stalls are inserted. A gap in op_valid simply waits.
- WAIT: operands and unit_funct5 are held stable.
  - The wait counter decrements each cycle.
  - On the edge where it reaches 0, unit_result is sampled into rsp_result, rsp_err is set to 0, and the state moves to RESP.
  - If the last operand is written at edge E, the result is sampled at edge E+LATENCY.
- RESP: rsp_valid=1; rsp_result and rsp_err are held.
  - On an rsp handshake, go to IDLE. Slots and unit_funct5 keep their values until the next command.
- Ignored inputs:
  - cmd_valid outside IDLE.
  - op_valid outside LOAD.
  - rsp_ready outside RESP.
- Back-to-back commands: RESP→IDLE costs one cycle. The earliest next cmd handshake is the cycle after the rsp handshake.
- Width rules: count is 5 bits and never exceeds 18. The wait counter is 4 bits. Operand values are passed unmodified; no bf16 arithmetic is done here.

Test Plan:
1. Reset is low for 15 ns then released → cmd_ready=1, busy=0, rsp_valid=0, all unit_in*=0x0000.
2. cmd funct5=5'b00001, nops=2; ops 0x4458, 0x3F80 → unit_in1=0x4458, unit_in2=0x3F80, unit_in3..18=0, unit_funct5=00001. Stub unit_result=0x4460 → rsp_valid with rsp_result=0x4460 and rsp_err=0.
3. Latency check: the stub drives unit_result = free-running cycle count. The captured rsp_result must equal the count at edge E+3 (LATENCY=3) after the last operand write.
4. nops=18, funct5=5'b00111, ops 0x3DF8, 0x3D55, … with op_valid toggling 1/0 → all 18 slots hold the values in order. Slot 17 is written only on the 18th handshake, and op_ready=0 afterwards.
5. nops=0, then nops=19 → each gives rsp_valid with rsp_err=1 and rsp_result=0x0000, with no LOAD phase (op_ready never high).
6. Hold rsp_ready=0 for 5 cycles, then pulse it; separately, assert reset in the middle of LOAD → the response stays held until the pulse. The mid-LOAD reset immediately forces IDLE with all slots at 0 and no response.
